// File: rtl/mb_uart_tx_arb.sv
// mb_uart_tx_arb
//   Round-robin arbiter/sequencer sharing one mbUartT transmitter among
//   NUM_REQ byte producers. One byte is granted at a time, loaded into the
//   transmitter with a one-cycle strobe, and the arbiter waits for the
//   transmitter's completion pulse. An optional idle gap follows each
//   completed frame, and a watchdog aborts a frame that never completes.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   req             level request per requester (data held while high)
//   req_data        byte of requester i on [8i+7:8i]
//   ack             one-cycle pulse: requester's byte captured
//   done            one-cycle pulse: requester's byte fully transmitted
//   err             one-cycle pulse: watchdog abort
//   busy            high whenever the sequencer is not idle
//   tx_data         byte to mbUartT data
//   tx_data_f       one-cycle load strobe to mbUartT data_f
//   tx_send_finish  one-cycle completion pulse from mbUartT send_finish
module mb_uart_tx_arb #(
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 0,
  parameter int TIMEOUT    = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   done,
  output logic                 err,
  output logic                 busy,
  output logic [7:0]           tx_data,
  output logic                 tx_data_f,
  input  logic                 tx_send_finish
);

  localparam int IW = (NUM_REQ > 1)    ? $clog2(NUM_REQ)      : 1;
  localparam int TW = (TIMEOUT > 1)    ? $clog2(TIMEOUT)      : 1;
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES+1) : 1;

  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ-1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT-1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES-1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_GAP} state_t;

  state_t                    state;
  logic [IW-1:0]             owner;
  logic [IW-1:0]             last_grant;
  logic [TW-1:0]             tmo_cnt;
  logic [GW-1:0]             gap_cnt;

  logic [NUM_REQ-1:0][7:0]   req_byte;
  logic [IW-1:0]             win;
  logic [IW-1:0]             cand;
  logic                      win_vld;

  assign req_byte = req_data;

  // Scan candidates last_grant+NUM_REQ down to last_grant+1 so the closest
  // requester after the previous winner is the last (and final) assignment.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IW'((int'(last_grant) + k) % NUM_REQ);
      if (req[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      owner      <= '0;
      last_grant <= LAST_IDX;
      tmo_cnt    <= '0;
      gap_cnt    <= '0;
      ack        <= '0;
      done       <= '0;
      err        <= 1'b0;
      busy       <= 1'b0;
      tx_data    <= 8'h00;
      tx_data_f  <= 1'b0;
    end else begin
      ack       <= '0;
      done      <= '0;
      err       <= 1'b0;
      tx_data_f <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (win_vld) begin
            tx_data    <= req_byte[win];
            ack[win]   <= 1'b1;
            owner      <= win;
            last_grant <= win;
            busy       <= 1'b1;
            state      <= S_START;
          end
        end
        S_START: begin
          tx_data_f <= 1'b1;
          tmo_cnt   <= '0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          // A finish landing on the timeout cycle still counts as success.
          if (tx_send_finish) begin
            done[owner] <= 1'b1;
            gap_cnt     <= '0;
            if (GAP_CYCLES > 0) begin
              state <= S_GAP;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            err   <= 1'b1;
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (tmo_cnt != '1) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mb_uart_tx_arb.sv
// Bench for mb_uart_tx_arb: directed requester traffic, a simple transmitter
// stand-in that answers each load strobe after frame_len cycles, and a
// transaction-level reference model compared every cycle.
module tb_mb_uart_tx_arb;
  localparam int NR  = 4;
  localparam int GAP = 16;
  localparam int TMO = 50;

  logic          clk;
  logic          rst;
  logic [NR-1:0] req;
  logic [31:0]   req_data;
  logic [NR-1:0] ack, done;
  logic          err, busy;
  logic [7:0]    tx_data;
  logic          tx_data_f;
  logic          tx_send_finish;

  mb_uart_tx_arb #(.NUM_REQ(NR), .GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .ack(ack), .done(done), .err(err), .busy(busy),
    .tx_data(tx_data), .tx_data_f(tx_data_f), .tx_send_finish(tx_send_finish)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a transaction is "in flight" from its grant until it
  // finishes or times out; age counts edges since the grant.
  typedef struct {
    bit         active;
    int         age;
    int         gap;
    int         rr;
    int         owner;
    logic [3:0] ack;
    logic [3:0] done;
    logic       err;
    logic       f;
    logic       busy;
    logic [7:0] txd;
  } mdl_t;

  function automatic mdl_t mdl_reset();
    mdl_t n;
    n.active = 0; n.age = 0; n.gap = 0; n.rr = NR-1; n.owner = 0;
    n.ack = '0; n.done = '0; n.err = 0; n.f = 0; n.busy = 0; n.txd = 8'h00;
    return n;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t s, input logic [3:0] r,
                                    input logic [31:0] d, input logic fin);
    mdl_t n = s;
    n.ack = '0; n.done = '0; n.err = 0; n.f = 0;
    if (n.active) begin
      n.age++;
      if (n.age == 1) n.f = 1;
      else if (fin) begin
        n.done = 4'(1 << n.owner); n.active = 0; n.gap = GAP;
      end else if (n.age == TMO + 1) begin
        n.err = 1; n.active = 0;
      end
    end else if (n.gap > 0) begin
      n.gap--;
    end else if (r != 0) begin
      for (int k = 1; k <= NR; k++) begin
        int i;
        i = (n.rr + k) % NR;
        if (r[i]) begin
          n.ack = 4'(1 << i); n.txd = d[8*i +: 8];
          n.owner = i; n.rr = i; n.active = 1; n.age = 0;
          break;
        end
      end
    end
    n.busy = n.active || (n.gap > 0);
    return n;
  endfunction

  mdl_t m;
  always @(posedge clk or posedge rst) begin
    if (rst) m <= mdl_reset();
    else     m <= mdl_step(m, req, req_data, tx_send_finish);
  end

  // Event logs and transmitter stand-in
  int         cyc = 0;
  int         ack_q[$];
  int         d2a_q[$];
  logic [7:0] uart_q[$];
  int         last_ack_cyc = 0, last_done_cyc = 0, last_err_cyc = 0;
  int         last_f_cyc = 0, fin_cyc = 0;
  int         done_cnt = 0, err_cnt = 0;
  int         uart_cnt = 0;
  int         frame_len = 20;
  bit         uart_mute = 0;

  initial begin
    tx_send_finish = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst !== 1'b1) begin
        chk("cycle", 32'({ack, done, err, busy, tx_data_f, tx_data}),
                     32'({m.ack, m.done, m.err, m.busy, m.f, m.txd}));
        if (ack != 0) begin
          for (int i = 0; i < NR; i++) if (ack[i]) ack_q.push_back(i);
          if (last_done_cyc > last_ack_cyc) d2a_q.push_back(cyc - last_done_cyc);
          last_ack_cyc = cyc;
        end
        if (done != 0) begin done_cnt++; last_done_cyc = cyc; end
        if (err)       begin err_cnt++;  last_err_cyc  = cyc; end
        if (tx_data_f) begin last_f_cyc = cyc; uart_q.push_back(tx_data); end
      end
      tx_send_finish = 1'b0;
      if (rst !== 1'b0) uart_cnt = 0;
      else begin
        if (uart_cnt > 0) begin
          uart_cnt--;
          if (uart_cnt == 0 && !uart_mute) begin tx_send_finish = 1'b1; fin_cyc = cyc; end
        end
        if (tx_data_f) uart_cnt = frame_len;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic wait_idle();
    int b = 0;
    while (busy !== 1'b0 && b < 3000) begin tick(1); b++; end
    if (busy !== 1'b0) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Raise mask, collect n acks (optionally dropping each acked requester),
  // then release everything and wait for the sequencer to go idle.
  task automatic serve(input logic [3:0] mask, input int n, input bit drop);
    int got = 0;
    int b = 0;
    req = mask;
    while (got < n && b < 3000) begin
      tick(1); b++;
      if (ack != 0) begin got++; if (drop) req = req & ~ack; end
    end
    req = '0;
    if (got < n) chk("serve_timeout", 32'(got), 32'(n));
    wait_idle();
  endtask

  int         exp_rr[5]   = '{0, 1, 2, 3, 0};
  logic [7:0] exp_rr_b[5] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
  int         d0, e0;

  initial begin
    rst = 1'b0; req = '0; req_data = '0;
    #2 rst = 1'b1;
    tick(2);
    chk("reset_out", 32'({ack, done, err, busy, tx_data_f, tx_data}), 32'd0);
    rst = 1'b0;
    tick(2);

    // Round-robin with all requesters held high
    req_data = {8'h43, 8'h32, 8'h21, 8'h10};
    ack_q.delete(); uart_q.delete(); d2a_q.delete();
    serve(4'b1111, 5, 1'b0);
    chk("rr_ack_count", 32'(ack_q.size()), 32'd5);
    if (ack_q.size() == 5)
      for (int i = 0; i < 5; i++) chk("rr_ack_order", 32'(ack_q[i]), 32'(exp_rr[i]));
    if (uart_q.size() == 5)
      for (int i = 0; i < 5; i++) chk("rr_byte", 32'(uart_q[i]), 32'(exp_rr_b[i]));
    chk("gap_count", 32'(d2a_q.size()), 32'd4);
    foreach (d2a_q[i]) chk("gap_done_to_ack", 32'(d2a_q[i]), 32'd17);

    // Single byte from requester 0
    req_data = 32'h0000_0084;
    ack_q.delete(); uart_q.delete(); d0 = done_cnt;
    serve(4'b0001, 1, 1'b1);
    chk("single_ack", 32'(ack_q.size() > 0 ? ack_q[0] : -1), 32'd0);
    chk("single_byte", 32'(uart_q.size() > 0 ? uart_q[0] : 8'hxx), 32'h84);
    chk("single_strobe_lat", 32'(last_f_cyc - last_ack_cyc), 32'd1);
    chk("single_done_lat", 32'(last_done_cyc - fin_cyc), 32'd1);
    chk("single_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("single_idle", 32'({busy, tx_data}), 32'h084);

    // Priority rotation: last grant 2, then 0 and 2 requesting
    req_data = 32'h0055_0000;
    serve(4'b0100, 1, 1'b1);
    req_data = 32'h0077_0066;
    ack_q.delete(); uart_q.delete();
    serve(4'b0101, 2, 1'b1);
    chk("prio_count", 32'(ack_q.size()), 32'd2);
    if (ack_q.size() == 2) begin
      chk("prio_first", 32'(ack_q[0]), 32'd0);
      chk("prio_second", 32'(ack_q[1]), 32'd2);
    end

    // Watchdog: transmitter never answers
    uart_mute = 1;
    req_data = 32'hA300_B100;
    ack_q.delete(); d0 = done_cnt; e0 = err_cnt;
    serve(4'b1010, 2, 1'b1);
    chk("wd_err_cnt", 32'(err_cnt - e0), 32'd2);
    chk("wd_done_cnt", 32'(done_cnt - d0), 32'd0);
    chk("wd_err_lat", 32'(last_err_cyc - last_f_cyc), 32'd50);
    if (ack_q.size() == 2) begin
      chk("wd_first", 32'(ack_q[0]), 32'd3);
      chk("wd_second", 32'(ack_q[1]), 32'd1);
    end else chk("wd_ack_count", 32'(ack_q.size()), 32'd2);
    uart_mute = 0;

    // Finish on the timeout cycle wins; one cycle later loses
    req_data = 32'h0000_005A;
    frame_len = 49; d0 = done_cnt; e0 = err_cnt;
    serve(4'b0001, 1, 1'b1);
    chk("tie_done", 32'(done_cnt - d0), 32'd1);
    chk("tie_err", 32'(err_cnt - e0), 32'd0);
    frame_len = 50; d0 = done_cnt; e0 = err_cnt;
    serve(4'b0001, 1, 1'b1);
    tick(5);
    chk("late_done", 32'(done_cnt - d0), 32'd0);
    chk("late_err", 32'(err_cnt - e0), 32'd1);
    frame_len = 20;

    // Reset in the middle of a frame
    req_data = 32'h0000_C100;
    req = 4'b0010;
    for (int b = 0; b < 100 && ack == 0; b++) tick(1);
    req = '0;
    tick(5);
    chk("mid_busy", 32'(busy), 32'd1);
    d0 = done_cnt; e0 = err_cnt;
    rst = 1'b1;
    #1;
    chk("mid_reset_out", 32'({ack, done, err, busy, tx_data_f, tx_data}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("mid_reset_hold", 32'({ack, done, err, busy, tx_data_f, tx_data}), 32'd0);
    end
    rst = 1'b0;
    tick(25);
    chk("mid_no_done", 32'(done_cnt - d0), 32'd0);
    chk("mid_no_err", 32'(err_cnt - e0), 32'd0);
    req_data = 32'hE300_00D0;
    ack_q.delete(); uart_q.delete();
    serve(4'b1001, 2, 1'b1);
    if (ack_q.size() == 2 && uart_q.size() == 2) begin
      chk("post_rst_first", 32'(ack_q[0]), 32'd0);
      chk("post_rst_second", 32'(ack_q[1]), 32'd3);
      chk("post_rst_byte0", 32'(uart_q[0]), 32'hD0);
      chk("post_rst_byte1", 32'(uart_q[1]), 32'hE3);
    end else chk("post_rst_count", 32'(ack_q.size()), 32'd2);

    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

endmodule
